decoder_scan: RTL and testbench

- Parametrised, registered binary-to-one-hot decoder with enable, generalised from the 2-to-4 enable decoder.
- Adds an auto-scan mode: an internal index sweeps all outputs, holding each for a programmable dwell time, e.g. for multiplexed display digit or row strobing.
- Sits between control logic and strobe or enable lines. Outputs are registered and glitch-free.

---
 rtl/decoder_scan.sv | 101 ++++++++++
 tb/tb_decoder_scan.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// decoder_scan: registered binary-to-one-hot decoder with enable and an
// auto-scan mode that sweeps every output, holding each for dwell+1 cycles.
// All outputs come straight from flops, so y never glitches and is always
// either all-zero or exactly one-hot with y[idx] set whenever valid is high.
module decoder_scan #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(2**SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap,
    output logic                    valid
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = '1;

    // Mode seen on the most recent enabled edge; a direct->scan change
    // makes the next scan edge a priming edge (dwell cycle 0).
    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

    mode_t                last_mode, last_mode_nxt;
    logic [DWELL_W-1:0]   cnt, cnt_nxt;
    logic [SEL_W-1:0]     idx_nxt;
    logic [OUT_W-1:0]     y_nxt;
    logic                 wrap_nxt;
    logic                 valid_nxt;
    logic                 advance;

    // Next-state computation for index, dwell counter and decoded outputs.
    always_comb begin
        idx_nxt       = idx;
        cnt_nxt       = cnt;
        y_nxt         = '0;
        wrap_nxt      = 1'b0;
        valid_nxt     = 1'b0;
        last_mode_nxt = last_mode;
        advance       = 1'b0;

        if (en) begin
            if (!mode) begin
                idx_nxt       = sel;
                cnt_nxt       = '0;
                valid_nxt     = 1'b1;
                last_mode_nxt = MODE_DIRECT;
            end else begin
                last_mode_nxt = MODE_SCAN;
                // First scan edge after direct mode treats cnt as 0 and only
                // steps when dwell is 0; afterwards the live dwell is compared,
                // so shrinking dwell mid-scan advances on the next edge.
                if (last_mode == MODE_DIRECT) begin
                    advance = (dwell == '0);
                end else begin
                    advance = (cnt >= dwell);
                end

                if (advance) begin
                    cnt_nxt  = '0;
                    idx_nxt  = idx + 1'b1;
                    wrap_nxt = (idx == IDX_MAX);
                end else if (last_mode == MODE_DIRECT) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
                valid_nxt = 1'b1;
            end

            y_nxt[idx_nxt] = 1'b1;
        end
    end

    // Output and state registers; en=0 clears outputs but keeps idx/cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            idx       <= '0;
            wrap      <= 1'b0;
            valid     <= 1'b0;
            cnt       <= '0;
            last_mode <= MODE_DIRECT;
        end else begin
            y         <= y_nxt;
            idx       <= idx_nxt;
            wrap      <= wrap_nxt;
            valid     <= valid_nxt;
            cnt       <= cnt_nxt;
            last_mode <= last_mode_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan (SEL_W=2, DWELL_W=8).
module tb_decoder_scan;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic [3:0] y;
    logic [1:0] idx;
    logic       wrap;
    logic       valid;

    int unsigned chk_cnt;
    int unsigned pass_cnt;

    decoder_scan #(
        .SEL_W   (2),
        .DWELL_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .dwell (dwell),
        .y     (y),
        .idx   (idx),
        .wrap  (wrap),
        .valid (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        sel   = '0;
        dwell = '0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] ey, input logic [1:0] ei,
                             input logic ew, input logic ev);
        check({tag, ".y"},     {28'd0, y},     {28'd0, ey});
        check({tag, ".idx"},   {30'd0, idx},   {30'd0, ei});
        check({tag, ".wrap"},  {31'd0, wrap},  {31'd0, ew});
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
    endtask

    logic [3:0] dir_y [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        rst_n    = 1'b0;
        en = 1'b0; mode = 1'b0; sel = '0; dwell = '0;

        // Reset state
        do_reset();
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Direct decode
        en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick(1);
            check_out($sformatf("direct%0d", i), dir_y[i], 2'(i), 1'b0, 1'b1);
        end
        sel = 2'd1;
        check("direct_latency", {28'd0, y}, 32'h8);
        tick(1);
        check("direct_after", {28'd0, y}, 32'h2);

        // Enable gating
        sel = 2'd2;
        tick(1);
        check_out("gate_pre", 4'b0100, 2'd2, 1'b0, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_out($sformatf("gate_off%0d", i), 4'b0000, 2'd2, 1'b0, 1'b0);
        end
        en = 1'b1;
        tick(1);
        check_out("gate_on", 4'b0100, 2'd2, 1'b0, 1'b1);

        // Scan dwell=2 from reset: idx 0,0,0,1,1,1,2,2,2,3,3,3,0..., wrap on edge 13
        do_reset();
        en = 1'b1; mode = 1'b1; dwell = 8'd2;
        for (int e = 1; e <= 16; e++) begin
            tick(1);
            check_out($sformatf("scan2_e%0d", e), dir_y[((e - 1) / 3) % 4],
                      2'(((e - 1) / 3) % 4), (e == 13), 1'b1);
        end

        // Scan dwell=0: advances every edge, wrap every 4th
        do_reset();
        en = 1'b1; mode = 1'b1; dwell = 8'd0;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            check_out($sformatf("scan0_e%0d", e), dir_y[e % 4], 2'(e % 4), (e % 4 == 0), 1'b1);
        end

        // Pause and resume: dwell=3, pause at idx=2 cnt=1 (edge 10)
        do_reset();
        en = 1'b1; mode = 1'b1; dwell = 8'd3;
        tick(10);
        check_out("pause_pre", 4'b0100, 2'd2, 1'b0, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_out($sformatf("paused%0d", i), 4'b0000, 2'd2, 1'b0, 1'b0);
        end
        en = 1'b1;
        tick(1);
        check_out("resume1", 4'b0100, 2'd2, 1'b0, 1'b1);
        tick(1);
        check_out("resume2", 4'b0100, 2'd2, 1'b0, 1'b1);
        tick(1);
        check_out("resume3", 4'b1000, 2'd3, 1'b0, 1'b1);

        // Live dwell shrink: cnt=0 at idx3, dwell->0 advances next edge with wrap
        dwell = 8'd0;
        tick(1);
        check_out("dwell_shrink", 4'b0001, 2'd0, 1'b1, 1'b1);

        // Scan -> direct follows sel next edge
        mode = 1'b0; sel = 2'd3;
        tick(1);
        check_out("to_direct", 4'b1000, 2'd3, 1'b0, 1'b1);

        // Async reset mid-scan
        do_reset();
        en = 1'b1; mode = 1'b1; dwell = 8'd2;
        tick(7);
        check_out("areset_pre", 4'b0100, 2'd2, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("areset", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check_out("restart3", 4'b0001, 2'd0, 1'b0, 1'b1);
        tick(1);
        check_out("restart4", 4'b0010, 2'd1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
